// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: selection-mode encodings
// and a ceiling-log2 helper for tool flows that lack $clog2.
package mux_pkg;

   localparam logic [1:0] MODE_STATIC = 2'b00;
   localparam logic [1:0] MODE_PRIO   = 2'b01;
   localparam logic [1:0] MODE_RR     = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   // Number of bits needed to index 'value' distinct items (minimum 1).
   function automatic int clog2(input int value);
      int bits;
      int span;
      bits = 0;
      span = 1;
      while (span < value) begin
         span = span * 2;
         bits = bits + 1;
      end
      if (bits == 0) begin
         bits = 1;
      end else begin
         bits = bits;
      end
      return bits;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: starting at ptr and wrapping from N-1
// to 0, the first requesting channel wins. With ptr tied to zero this is a
// plain fixed-priority (lowest index wins) arbiter.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          gnt_vld,
   output logic [SW-1:0] gnt_idx
);

   int cand_s;

   // Walk the offsets from farthest to nearest so the channel closest to ptr is assigned last and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = {SW{1'b0}};
      cand_s  = 0;
      for (int k = N - 1; k >= 0; k--) begin
         cand_s = int'(ptr) + k;
         if (cand_s >= N) begin
            cand_s = cand_s - N;
         end else begin
            cand_s = cand_s;
         end
         if ((cand_s < N) && req[cand_s]) begin
            gnt_vld = 1'b1;
            gnt_idx = SW'(cand_s);
         end else begin
            gnt_vld = gnt_vld;
         end
      end
   end

endmodule

// File: rtl/stream_mux_nxw.sv
// Registered N-input, W-bit stream multiplexer with valid/ready handshake.
// Selection is static, fixed priority or round-robin; a hold mode lets the
// output register drain without accepting new words.
module stream_mux_nxw
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 3,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   output logic [N-1:0]    in_ready,
   input  logic [1:0]      mode,
   input  logic [SW-1:0]   sel,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   input  logic            out_ready
);

   logic          out_valid_r;
   logic [W-1:0]  out_data_r;
   logic [SW-1:0] out_ch_r;
   logic [SW-1:0] ptr_r;

   logic          load_s;
   logic          gnt_vld_s;
   logic [SW-1:0] gnt_idx_s;
   logic          rr_vld_s;
   logic [SW-1:0] rr_idx_s;
   logic          pr_vld_s;
   logic [SW-1:0] pr_idx_s;
   logic          sel_ok_s;
   logic          xfer_s;
   logic [SW-1:0] ptr_next_s;
   logic [N-1:0]  ready_s;

   rr_arbiter #(.N(N)) u_rr_arb (
      .req     (in_valid),
      .ptr     (ptr_r),
      .gnt_vld (rr_vld_s),
      .gnt_idx (rr_idx_s)
   );

   rr_arbiter #(.N(N)) u_prio_arb (
      .req     (in_valid),
      .ptr     ({SW{1'b0}}),
      .gnt_vld (pr_vld_s),
      .gnt_idx (pr_idx_s)
   );

   // The output register may take a new word when it is empty or being popped.
   assign load_s   = !out_valid_r || out_ready;
   assign sel_ok_s = (int'(sel) < N);
   assign xfer_s   = load_s && gnt_vld_s;

   // Mode mux: pick which arbiter result (if any) drives the grant.
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_idx_s = {SW{1'b0}};
      case (mode)
         MODE_STATIC: begin
            gnt_idx_s = sel;
            if (sel_ok_s) begin
               gnt_vld_s = in_valid[sel];
            end else begin
               gnt_vld_s = 1'b0;
            end
         end
         MODE_PRIO: begin
            gnt_vld_s = pr_vld_s;
            gnt_idx_s = pr_idx_s;
         end
         MODE_RR: begin
            gnt_vld_s = rr_vld_s;
            gnt_idx_s = rr_idx_s;
         end
         MODE_HOLD: begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = {SW{1'b0}};
         end
         default: begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = {SW{1'b0}};
         end
      endcase
   end

   // One-hot ready toward the granted producer, forced low while in reset.
   always_comb begin
      ready_s = {N{1'b0}};
      if (rst_n && xfer_s) begin
         ready_s[gnt_idx_s] = 1'b1;
      end else begin
         ready_s = {N{1'b0}};
      end
   end

   // Round-robin pointer advances past the served channel, wrapping explicitly for non-power-of-2 N.
   always_comb begin
      ptr_next_s = ptr_r;
      if (xfer_s && (mode == MODE_RR)) begin
         if (gnt_idx_s == SW'(N - 1)) begin
            ptr_next_s = {SW{1'b0}};
         end else begin
            ptr_next_s = gnt_idx_s + SW'(1);
         end
      end else begin
         ptr_next_s = ptr_r;
      end
   end

   // Output register stage: capture the granted word, clear valid when idle, freeze on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {W{1'b0}};
         out_ch_r    <= {SW{1'b0}};
      end else if (load_s) begin
         if (gnt_vld_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[gnt_idx_s*W +: W];
            out_ch_r    <= gnt_idx_s;
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Round-robin start pointer; restarts at channel 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {SW{1'b0}};
      end else begin
         ptr_r <= ptr_next_s;
      end
   end

   assign in_ready  = ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_nxw.sv
// Self-checking bench for stream_mux_nxw: an N=4 and an N=3 instance share
// mode/out_ready/reset and are checked every falling edge against a
// behavioural model, plus hand-computed literal expectations.
module tb_stream_mux_nxw;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       out_ready;

   logic [3:0]  v4, rdy4;
   logic [11:0] d4;
   logic [1:0]  sel4, oc4;
   logic        ov4;
   logic [2:0]  od4;

   logic [2:0]  v3, rdy3;
   logic [8:0]  d3;
   logic [1:0]  sel3, oc3;
   logic        ov3;
   logic [2:0]  od3;

   int n_cmp = 0;
   int n_bad = 0;

   bit mv[2];
   int mdat[2];
   int mch[2];
   int mptr[2];

   int e4[5]  = '{0, 1, 2, 3, 0};
   int ed4[5] = '{1, 2, 5, 6, 1};
   int e3[5]  = '{0, 1, 2, 0, 1};
   int ed3[5] = '{3, 4, 7, 3, 4};
   logic [3:0] vt[8] = '{4'b0101, 4'b1111, 4'b0010, 4'b1100, 4'b0000, 4'b1001, 4'b0110, 4'b1000};

   always #5 clk = ~clk;

   stream_mux_nxw #(.N(4), .W(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
      .mode(mode), .sel(sel4), .out_valid(ov4), .out_data(od4), .out_ch(oc4),
      .out_ready(out_ready)
   );

   stream_mux_nxw #(.N(3), .W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
      .mode(mode), .sel(sel3), .out_valid(ov3), .out_data(od3), .out_ch(oc3),
      .out_ready(out_ready)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Grant rules straight from the mode definitions.
   task automatic grant(input int n, input logic [1:0] md, input int s, input logic [3:0] v,
                        input int p, output bit gv, output int gi);
      gv = 0;
      gi = 0;
      case (md)
         2'b00: if (s < n && v[s]) begin gv = 1; gi = s; end
         2'b01: for (int k = 0; k < n; k++) if (!gv && v[k]) begin gv = 1; gi = k; end
         2'b10: for (int k = 0; k < n; k++) if (!gv && v[(p + k) % n]) begin gv = 1; gi = (p + k) % n; end
         default: gv = 0;
      endcase
   endtask

   // Model compare on every falling edge, then advance the model across the next rising edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int n, s, a_od, a_oc, a_rdy, gi, erdy;
         logic [3:0] v;
         logic [11:0] d;
         bit a_ov, gv, ld;
         if (i == 0) begin
            n = 4; v = v4; s = int'(sel4); d = d4;
            a_ov = ov4; a_od = int'(od4); a_oc = int'(oc4); a_rdy = int'(rdy4);
         end else begin
            n = 3; v = {1'b0, v3}; s = int'(sel3); d = {3'b000, d3};
            a_ov = ov3; a_od = int'(od3); a_oc = int'(oc3); a_rdy = int'(rdy3);
         end
         if (!rst_n) begin
            mv[i] = 0; mdat[i] = 0; mch[i] = 0; mptr[i] = 0;
         end
         chk($sformatf("model_out_valid_n%0d", n), int'(a_ov), int'(mv[i]));
         chk($sformatf("model_out_data_n%0d", n), a_od, mdat[i]);
         chk($sformatf("model_out_ch_n%0d", n), a_oc, mch[i]);
         ld = !mv[i] || out_ready;
         gv = 0; gi = 0;
         if (rst_n) grant(n, mode, s, v, mptr[i], gv, gi);
         erdy = (ld && gv) ? (1 << gi) : 0;
         chk($sformatf("model_in_ready_n%0d", n), a_rdy, erdy);
         if (rst_n && ld) begin
            if (gv) begin
               mv[i] = 1;
               mdat[i] = int'(d[gi*3 +: 3]);
               mch[i] = gi;
               if (mode == 2'b10) mptr[i] = (gi + 1) % n;
            end else begin
               mv[i] = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; mode = 2'b10; out_ready = 1'b1;
      v4 = 4'hF; v3 = 3'h7; sel4 = 2'd2; sel3 = 2'd3;
      d4 = {3'd6, 3'd5, 3'd2, 3'd1};
      d3 = {3'd7, 3'd4, 3'd3};
      step(); step();
      chk("reset_out_valid", int'(ov4), 0);
      chk("reset_in_ready4", int'(rdy4), 0);
      chk("reset_in_ready3", int'(rdy3), 0);
      rst_n = 1'b1;

      // Round-robin sequences from reset, no bubbles
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr4_ch_seq", int'(oc4), e4[k]);
         chk("rr4_data_seq", int'(od4), ed4[k]);
         chk("rr4_valid", int'(ov4), 1);
         chk("rr3_ch_seq", int'(oc3), e3[k]);
         chk("rr3_data_seq", int'(od3), ed3[k]);
      end

      // Back-pressure: outputs frozen, no ready
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_in_ready", int'(rdy4), 0);
         chk("stall_out_ch", int'(oc4), 0);
         chk("stall_out_data", int'(od4), 1);
         chk("stall_out_valid", int'(ov4), 1);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", int'(rdy4), 4'b0010);
      step();
      chk("release_push_ch", int'(oc4), 1);
      chk("release_push_data", int'(od4), 2);
      chk("release_push_ch3", int'(oc3), 2);

      // Static select
      mode = 2'b00;
      #1;
      chk("static_in_ready", int'(rdy4), 4'b0100);
      chk("static_sel_oob_ready", int'(rdy3), 0);
      step();
      chk("static_out_data", int'(od4), 5);
      chk("static_out_ch", int'(oc4), 2);
      chk("static_sel_oob_valid", int'(ov3), 0);
      v4 = 4'b1011;
      #1;
      chk("static_sel_invalid_ready", int'(rdy4), 0);
      step();
      chk("static_sel_invalid_valid", int'(ov4), 0);
      chk("static_hold_data", int'(od4), 5);

      // Fixed priority: ch1 starves ch3
      mode = 2'b01; v4 = 4'b1010; v3 = 3'b010;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("prio_out_ch", int'(oc4), 1);
         chk("prio_in_ready", int'(rdy4), 4'b0010);
      end
      v4 = 4'b1000;
      step();
      chk("prio_ch3_after_drop", int'(oc4), 3);
      chk("prio_ch3_data", int'(od4), 6);

      // Round-robin resumes from stored pointers, then hold drains
      mode = 2'b10; v4 = 4'hF; v3 = 3'h7;
      step();
      chk("rr_resume4_a", int'(oc4), 2);
      chk("rr_resume3_a", int'(oc3), 0);
      step();
      chk("rr_resume4_b", int'(oc4), 3);
      chk("rr_resume3_b", int'(oc3), 1);
      mode = 2'b11;
      step();
      chk("hold_drained_valid", int'(ov4), 0);
      chk("hold_in_ready", int'(rdy4), 0);
      step();
      chk("hold_stays_empty", int'(ov4), 0);
      mode = 2'b10;
      #1;
      chk("hold_resume_ready4", int'(rdy4), 4'b0001);
      chk("hold_resume_ready3", int'(rdy3), 3'b100);
      step();
      chk("hold_resume_ch4", int'(oc4), 0);
      chk("hold_resume_ch3", int'(oc3), 2);

      // Mixed directed table, model-checked
      for (int k = 0; k < 16; k++) begin
         v4 = vt[k % 8];
         v3 = vt[(k + 3) % 8][2:0];
         out_ready = ((k % 3) != 2);
         mode = (k < 8) ? 2'b10 : 2'b01;
         step();
      end

      // Reset mid-stream
      mode = 2'b10; v4 = 4'hF; v3 = 3'h7; out_ready = 1'b1;
      step(); step();
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", int'(ov4), 0);
      chk("midreset_out_data", int'(od4), 0);
      chk("midreset_out_ch", int'(oc4), 0);
      chk("midreset_in_ready", int'(rdy4), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("postreset_ch4", int'(oc4), 0);
      chk("postreset_valid4", int'(ov4), 1);
      chk("postreset_ch3", int'(oc3), 0);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_mux_nxw.md
# stream_mux_nxw

Registered N-input, W-bit stream multiplexer with valid/ready handshaking and three selection modes: static select, fixed priority and round-robin. Successor to the team's combinational 2:1 n-bit mux. It sits wherever several producers share one consumer and back-pressure must propagate. One output register stage gives full throughput of one word per cycle.

## Interface
- N, default 4: number of input channels, N ≥ 2.
- W, default 3: data width per channel, W ≥ 1.
- SW, default $clog2(N): width of the select and channel-ID fields. Derived; never overridden.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready; at most one bit high.
- mode  input  2  00 static, 01 fixed priority, 10 round-robin, 11 hold.
- sel  input  SW  channel used in static mode.
- out_valid  output  1  registered output valid.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

## Operation
- load = !out_valid || out_ready.
- Grant is combinational from in_valid, mode, sel and ptr; it yields gnt_vld and gnt_idx.
- mode 00: gnt_vld = (sel < N) && in_valid[sel]; gnt_idx = sel. If sel ≥ N, nothing is granted.
- mode 01: the lowest-index valid channel wins.
- mode 10: search from ptr upward, wrapping N-1 to 0. The first valid channel wins.
- mode 11: no grant. The output register drains; nothing new is accepted.
- in_ready[i] = load && gnt_vld && (gnt_idx == i). All other in_ready bits are 0.
- On each rising edge, when load is 1:
  - gnt_vld=1: out_valid←1, out_data←in_data[gnt_idx], out_ch←gnt_idx.
  - gnt_vld=0: out_valid←0. out_data and out_ch keep their values.
- When load is 0, all output registers hold. Data must not change while out_valid=1 and out_ready=0.
- ptr (SW bits) changes only on an input transfer in mode 10. It is then set to (gnt_idx+1) mod N, with explicit wrap for non-power-of-2 N.
- Mode changes take effect on the next arbitration. They never disturb a word already in the output register.
- in_ready does not depend on in_valid of the same channel except through the grant. It depends on out_ready combinationally, which is accepted.

## Timing
- Reset (asynchronous assert, synchronous-edge release): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is all 0 while rst_n=0.
- Latency is 1 cycle: a word accepted at edge k appears on out_data after edge k.
- Throughput is 1 word/cycle while out_ready=1 and any channel is granted.
- Simultaneous pop and push (out_valid=1, out_ready=1, grant present): the register is overwritten at the same edge with no bubble.
- Stall: with out_ready=0 and out_valid=1, in_ready is all 0 and the outputs are frozen.
- Reset mid-transfer: the word in flight is discarded. After release, round-robin restarts from channel 0.
- Channel dropping valid: a producer dropping in_valid without a handshake is a producer protocol violation. The block simply re-arbitrates every cycle.

## Structure
- Shared package mux_pkg holds:
  - the mode encodings MODE_STATIC=2'b00, MODE_PRIO=2'b01, MODE_RR=2'b10, MODE_HOLD=2'b11;
  - a clog2-style helper function if the tool flow lacks $clog2.
- Sub-module rr_arbiter (parameter N) holds the combinational round-robin search:
  - inputs: req[N-1:0], ptr;
  - outputs: gnt_vld, gnt_idx.
  - Top level: fixed priority is implemented as rr_arbiter with ptr forced to 0.
- The top level holds the mode mux, the handshake logic, the output register and the ptr register.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately. After release, mode 10 with all valid grants ch0 first.
- Static: N=4, W=3, mode 00, sel=2, in_data ch2=3'b101, all valid, out_ready=1 → in_ready=4'b0100, then out_data=5 and out_ch=2 next cycle. With sel=2 and in_valid[2]=0, no grant even though the others are valid.
- Fixed priority: in_valid=4'b1010, mode 01 → ch1 granted every cycle; ch3 starves until in_valid[1]=0.
- Round-robin: all four valid, out_ready=1, mode 10 → out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles. Also run N=3 to check the wrap 2→0.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1 → out_data and out_ch are stable and in_ready=0. Release with simultaneous pop/push → the next word lands in the same cycle and no word is lost or duplicated, checked by scoreboard.
- Hold mode: switch to mode 11 while out_valid=1 and out_ready=1 → one word drains, then out_valid=0 and in_ready=0. Switching back to mode 10 resumes from the stored ptr.
